// File: rtl/sbox_bram_port_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sbox_bram_port_ctrl_pkg
// Description : Shared masked-AES constants for the S-box BRAM port controller
// Revision    : 1.0 - initial release
// ============================================================================
package sbox_bram_port_ctrl_pkg;

  localparam int SEL_W    = 2;
  localparam int TAG_W    = 4;
  localparam int BRAM_LAT = 2;
  localparam int ADDR_W   = 8 + SEL_W;

  function automatic logic [1:0] occ_count(input logic v1, input logic v2);
    return {1'b0, v1} + {1'b0, v2};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sbox_valid_pipe
// Description : Two-stage valid/tag shift pipeline with hold, tracking the BRAM
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_valid_pipe #(
  parameter int TAG_W = sbox_bram_port_ctrl_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             advance_i,
  input  logic             valid_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             v1_o,
  output logic             v2_o,
  output logic [TAG_W-1:0] t2_o
);
  import sbox_bram_port_ctrl_pkg::*;

  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic [TAG_W-1:0] t1_q, t1_d;
  logic [TAG_W-1:0] t2_q, t2_d;

  // Flush only drops the valid bits; stale tags are masked downstream.
  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    t1_d = t1_q;
    t2_d = t2_q;
    if (flush_i) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end else if (advance_i) begin
      v1_d = valid_i;
      t1_d = tag_i;
      v2_d = v1_q;
      t2_d = t1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      t1_q <= '0;
      t2_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      t1_q <= t1_d;
      t2_q <= t2_d;
    end
  end

  assign v1_o = v1_q;
  assign v2_o = v2_q;
  assign t2_o = t2_q;

endmodule
`default_nettype wire

// File: rtl/sbox_bram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sbox_bram_port_ctrl
// Description : Dual-port BRAM S-box lookup controller with ready/valid flow
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_bram_port_ctrl #(
  parameter int SEL_W = sbox_bram_port_ctrl_pkg::SEL_W,
  parameter int TAG_W = sbox_bram_port_ctrl_pkg::TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [SEL_W-1:0]   in_sel_i,
  input  logic [7:0]         in_a_i,
  input  logic [7:0]         in_b_i,
  input  logic [TAG_W-1:0]   in_tag_i,
  output logic [SEL_W+7:0]   bram_addra_o,
  output logic [SEL_W+7:0]   bram_addrb_o,
  output logic               bram_en_o,
  output logic               bram_rst_o,
  input  logic [7:0]         bram_doa_i,
  input  logic [7:0]         bram_dob_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [7:0]         out_a_o,
  output logic [7:0]         out_b_o,
  output logic [TAG_W-1:0]   out_tag_o,
  output logic [1:0]         occupancy_o
);
  import sbox_bram_port_ctrl_pkg::*;

  logic             w_advance;
  logic             w_accept;
  logic             w_v1;
  logic             w_v2;
  logic [TAG_W-1:0] w_t2;

  assign bram_addra_o = {in_sel_i, in_a_i};
  assign bram_addrb_o = {in_sel_i, in_b_i};

  // The BRAM read and output registers move only with the valid pipe.
  assign w_advance  = ~w_v2 | out_ready_i;
  assign bram_en_o  = w_advance;
  assign bram_rst_o = rst;
  assign in_ready_o = w_advance & ~rst & ~flush_i;
  assign w_accept   = in_valid_i & in_ready_o;

  sbox_valid_pipe #(
    .TAG_W (TAG_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush_i),
    .advance_i (w_advance),
    .valid_i   (w_accept),
    .tag_i     (in_tag_i),
    .v1_o      (w_v1),
    .v2_o      (w_v2),
    .t2_o      (w_t2)
  );

  // Masked shares are forced to zero when no result is presented.
  assign out_valid_o = w_v2;
  assign out_a_o     = w_v2 ? bram_doa_i : 8'h00;
  assign out_b_o     = w_v2 ? bram_dob_i : 8'h00;
  assign out_tag_o   = w_v2 ? w_t2 : '0;
  assign occupancy_o = occ_count(w_v1, w_v2);

endmodule
`default_nettype wire

// File: tb/tb_sbox_bram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sbox_bram_port_ctrl
// Description : Self-checking bench with attached BRAM model and queue model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sbox_bram_port_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_sel = '0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [3:0] in_tag = '0;
  logic [9:0] addra, addrb;
  logic       bram_en, bram_rst;
  logic [7:0] doa, dob;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_a, out_b;
  logic [3:0] out_tag;
  logic [1:0] occupancy;

  always #5 clk = ~clk;

  sbox_bram_port_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_sel_i     (in_sel),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .in_tag_i     (in_tag),
    .bram_addra_o (addra),
    .bram_addrb_o (addrb),
    .bram_en_o    (bram_en),
    .bram_rst_o   (bram_rst),
    .bram_doa_i   (doa),
    .bram_dob_i   (dob),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_a_o      (out_a),
    .out_b_o      (out_b),
    .out_tag_o    (out_tag),
    .occupancy_o  (occupancy)
  );

  // BRAM_7_x26: dual-port ROM, array read register then output register.
  logic [7:0] mem [1024];
  logic [7:0] s1a, s1b;
  always @(posedge clk) begin
    if (bram_rst) begin
      s1a <= 8'h00; s1b <= 8'h00; doa <= 8'h00; dob <= 8'h00;
    end else if (bram_en) begin
      s1a <= mem[addra]; s1b <= mem[addrb];
      doa <= s1a;        dob <= s1b;
    end
  end

  // Reference model: ordered queue of in-flight lookups with their age.
  typedef struct {
    logic [7:0] ra;
    logic [7:0] rb;
    logic [3:0] tag;
    int         age;
  } ent_t;
  ent_t mq[$];

  int nvec = 0;
  int nmis = 0;
  int dut_hs = 0;

  logic        e_head, e_adv, e_inrdy;
  logic [45:0] e_vec;
  logic [45:0] obs;
  assign obs = {out_valid, out_a, out_b, out_tag, occupancy, in_ready,
                bram_en, bram_rst, addra, addrb};

  task automatic model_eval();
    logic [7:0] ea, eb;
    logic [3:0] et;
    e_head  = (mq.size() > 0) && (mq[0].age >= 2);
    e_adv   = !e_head || out_ready;
    e_inrdy = e_adv && !rst && !flush;
    ea = e_head ? mq[0].ra  : 8'h00;
    eb = e_head ? mq[0].rb  : 8'h00;
    et = e_head ? mq[0].tag : 4'h0;
    e_vec = {e_head, ea, eb, et, 2'(mq.size()), e_inrdy, e_adv, rst,
             {in_sel, in_a}, {in_sel, in_b}};
  endtask

  task automatic model_tick();
    ent_t e;
    if (rst || flush) begin
      mq.delete();
    end else if (e_adv) begin
      if (e_head) void'(mq.pop_front());
      foreach (mq[i]) mq[i].age++;
      if (in_valid && e_inrdy) begin
        e.ra = mem[{in_sel, in_a}]; e.rb = mem[{in_sel, in_b}];
        e.tag = in_tag; e.age = 1;
        mq.push_back(e);
      end
    end
  endtask

  task automatic set_in(input logic v, input logic [1:0] sel, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] tag,
                        input logic ordy, input logic fl, input logic rs);
    @(negedge clk);
    in_valid = v; in_sel = sel; in_a = a; in_b = b; in_tag = tag;
    out_ready = ordy; flush = fl; rst = rs;
    #1;
    model_eval();
    if (out_valid && out_ready) dut_hs++;
  endtask

  task automatic clock_model();
    @(posedge clk);
    model_tick();
  endtask

  task automatic test_reset();
    set_in($urandom, 2'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 1'b1, 1'b0, 1'b1);
    clock_model();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 2'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 1'b0, i < 2);
      nvec++;
      if (obs !== e_vec) begin
        nmis++; $display("FAIL reset cyc%0d got %h exp %h", i, obs, e_vec);
      end
      clock_model();
    end
    set_in(1'b0, 2'd0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1);
    clock_model();
    set_in(1'b0, 2'd0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0);
    nvec++;
    if ({out_valid, out_a, out_b, out_tag, occupancy, in_ready} !== {1'b0, 8'h00, 8'h00, 4'h0, 2'd0, 1'b1}) begin
      nmis++; $display("FAIL reset_state got %h exp %h", {out_valid, out_a, out_b, out_tag, occupancy, in_ready}, 24'h000001);
    end
  endtask

  task automatic test_single();
    set_in(1'b1, 2'd0, 8'h00, 8'h04, 4'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (obs !== e_vec) begin
        nmis++; $display("FAIL single cyc%0d got %h exp %h", i, obs, e_vec);
      end
      if (i == 2) begin
        nvec++;
        if ({out_valid, out_a, out_b, out_tag} !== {1'b1, 8'h00, 8'h17, 4'd3}) begin
          nmis++; $display("FAIL single_result got %h exp %h", {out_valid, out_a, out_b, out_tag}, {1'b1, 8'h00, 8'h17, 4'd3});
        end
      end
      clock_model();
      set_in(1'b0, 2'd0, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_stream();
    int hs0 = dut_hs;
    for (int i = 0; i < 260; i++) begin
      set_in(i < 256, 2'($urandom), 8'(i), 8'($urandom), 4'(i), 1'b1, 1'b0, 1'b0);
      nvec++;
      if (obs !== e_vec) begin
        nmis++; $display("FAIL stream cyc%0d got %h exp %h", i, obs, e_vec);
      end
      clock_model();
    end
    set_in(1'b0, 2'd0, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    nvec++;
    if (dut_hs - hs0 !== 256) begin
      nmis++; $display("FAIL stream_count got %0d exp %0d", dut_hs - hs0, 256);
    end
  endtask

  task automatic test_stall();
    logic [15:0] held;
    for (int i = 0; i < 12; i++) begin
      set_in(1'b1, 2'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
             (i >= 7), 1'b0, 1'b0);
      nvec++;
      if (obs !== e_vec) begin
        nmis++; $display("FAIL stall cyc%0d got %h exp %h", i, obs, e_vec);
      end
      if (i == 2) held = {out_a, out_b};
      if (i >= 2 && i < 7) begin
        nvec++;
        if ({in_ready, occupancy, out_a, out_b} !== {1'b0, 2'd2, held}) begin
          nmis++; $display("FAIL stall_hold cyc%0d got %h exp %h", i, {in_ready, occupancy, out_a, out_b}, {1'b0, 2'd2, held});
        end
      end
      clock_model();
    end
  endtask

  task automatic test_bubble();
    for (int i = 0; i < 36; i++) begin
      set_in((i % 3) != 1, 2'($urandom), 8'($urandom), 8'($urandom), 4'(i),
             1'(i % 2), 1'b0, 1'b0);
      nvec++;
      if (obs !== e_vec) begin
        nmis++; $display("FAIL bubble cyc%0d got %h exp %h", i, obs, e_vec);
      end
      clock_model();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 2'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
             (i == 2), (i == 2), 1'b0);
      nvec++;
      if (obs !== e_vec) begin
        nmis++; $display("FAIL flush cyc%0d got %h exp %h", i, obs, e_vec);
      end
      if (i == 3) begin
        nvec++;
        if ({out_valid, occupancy, out_a, out_b} !== 19'd0) begin
          nmis++; $display("FAIL flush_clear got %h exp %h", {out_valid, occupancy, out_a, out_b}, 19'd0);
        end
      end
      clock_model();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 24; i++) begin
      set_in(1'b1, 2'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
             1'b1, 1'b0, (i == 8));
      nvec++;
      if (obs !== e_vec) begin
        nmis++; $display("FAIL rst_mid cyc%0d got %h exp %h", i, obs, e_vec);
      end
      if (i == 9) begin
        nvec++;
        if ({out_valid, out_a, out_b, out_tag, occupancy} !== 23'd0) begin
          nmis++; $display("FAIL rst_mid_zero got %h exp %h", {out_valid, out_a, out_b, out_tag, occupancy}, 23'd0);
        end
      end
      clock_model();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom), 8'($urandom),
             4'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0,
             $urandom_range(0, 60) == 0);
      nvec++;
      if (obs !== e_vec) begin
        nmis++; $display("FAIL random cyc%0d got %h exp %h", i, obs, e_vec);
      end
      clock_model();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h00;
    mem[4] = 8'h17;
    test_reset();
    test_single();
    test_stream();
    test_stall();
    test_bubble();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sbox_bram_port_ctrl.md
SBOX_BRAM_PORT_CTRL -- requirements
Module: sbox_bram_port_ctrl

Interface
REQ-001 Parameter SEL_W, default 2: table-select bits prepended to each share byte; BRAM address width = 8+SEL_W (10).
REQ-002 Parameter TAG_W, default 4: width of the sideband tag carried alongside each byte pair.
REQ-003 clk  in  1  single clock for all logic and both BRAM ports.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 flush  in  1  synchronous pipeline clear; does not reset the BRAM.
REQ-006 in_valid  in  1  input byte pair present.
REQ-007 in_ready  out  1  block accepts the input this cycle.
REQ-008 in_sel  in  SEL_W  table select, the upper address bits.
REQ-009 in_a, in_b  in  8 each  masked share bytes for port A and port B.
REQ-010 in_tag  in  TAG_W  sideband tag.
REQ-011 bram_addra, bram_addrb  out  10 each  BRAM port addresses.
REQ-012 bram_en  out  1  drives the BRAM EN (ENA/ENB/REGCEA/REGCEB).
REQ-013 bram_rst  out  1  drives the BRAM rst.
REQ-014 bram_doa, bram_dob  in  8 each  BRAM registered read data.
REQ-015 out_valid  out  1  result pair present.
REQ-016 out_ready  in  1  consumer accepts the result.
REQ-017 out_a, out_b  out  8 each  looked-up share bytes.
REQ-018 out_tag  out  TAG_W  tag of the current result.
REQ-019 occupancy  out  2  number of valid entries in flight (0..2).

Function
REQ-020 Addresses SHALL be combinational: bram_addra={in_sel,in_a}, bram_addrb={in_sel,in_b}.
REQ-021 The pipeline SHALL have two stages matching the BRAM latency (array read plus output register), with valid bits v1, v2 and tag registers t1, t2.
REQ-022 advance = ~v2 | out_ready; bram_en = advance; in_ready = advance & ~rst & ~flush.
REQ-023 On advance: v1<=in_valid&in_ready, t1<=in_tag, v2<=v1, t2<=t1; otherwise v1, v2, t1, t2 hold and the BRAM holds because EN is low.
REQ-024 Latency SHALL be exactly 2 cycles with no stall: accepted at edge N, out_valid=1 after edge N+2.
REQ-025 Bubbles SHALL collapse: with v2=0, the pipeline advances regardless of out_ready.
REQ-026 Full throughput: one pair per cycle is sustained while out_ready=1.
REQ-027 out_a/out_b SHALL equal bram_doa/bram_dob when out_valid=1, and 8'h00 when out_valid=0, so no stale share is exposed.
REQ-028 out_tag=t2 when out_valid=1, else 0.
REQ-029 occupancy = v1+v2.
REQ-030 flush SHALL clear v1 and v2 at the next edge; in_valid in the same cycle is dropped; flush overrides advance.
REQ-031 A simultaneous flush and out_ready SHALL NOT produce a handshake after the edge: out_valid=0.
REQ-032 A data stall SHALL hold out_a, out_b, and out_tag stable while out_valid=1 and out_ready=0.

Reset
REQ-033 rst SHALL clear v1, v2, t1, and t2; bram_rst=rst.
REQ-034 After reset, out_valid=0, out_a=out_b=0, out_tag=0, occupancy=0, and in_ready=1 from the first cycle with rst=0.
REQ-035 Reset mid-operation SHALL discard all in-flight entries without emitting them.

Structure
REQ-036 SEL_W, TAG_W, BRAM latency (2), and address width SHALL be defined in the shared masked-AES package.
REQ-037 One sub-module, sbox_valid_pipe (a valid/tag shift pipeline with hold), SHALL hold v1/v2/t1/t2; the BRAM instance stays outside this block.

Verification (bench attaches BRAM_7_x26)
REQ-038 Reset, then in_valid=1, sel=0, a=0x00, b=0x04, tag=3 -> out_valid after 2 edges, out_a=0x00, out_b=0x17, out_tag=3.
REQ-039 Back-to-back stream of 256 pairs with out_ready=1 -> 256 results in order, one per cycle; each matches the table model.
REQ-040 Hold out_ready=0 for 5 cycles with 2 entries in flight -> in_ready=0, occupancy=2, outputs stable; on release, both entries emit in order and none are lost.
REQ-041 Input pattern valid-bubble-valid while out_ready toggles -> the bubble collapses, and tags arrive in order with no duplication.
REQ-042 Assert flush with occupancy=2 -> next cycle out_valid=0, occupancy=0, out_a=out_b=0.
REQ-043 Assert rst mid-stream -> no further results appear, all outputs read 0, and the stream resumes correctly after rst deasserts.
